// File: rtl/test_ram_arbiter.sv
// Shares the single test-RAM read port between instruction fetch and data read.
// Build option: define TEST_RAM_ARB_FIXED_PRIO_EN for fixed fetch-first priority instead of round-robin.
module test_ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifetch_req,
  input  logic [ADDR_WIDTH-1:0] ifetch_addr,
  output logic                  ifetch_ack,
  output logic                  ifetch_valid,
  output logic [DATA_WIDTH-1:0] ifetch_data,
  input  logic                  dread_req,
  input  logic [ADDR_WIDTH-1:0] dread_addr,
  output logic                  dread_ack,
  output logic                  dread_valid,
  output logic [DATA_WIDTH-1:0] dread_data,
  output logic                  ram_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  // Handshake: a requester holds req/addr until its one-cycle ack; ack marks the
  // RAM issue cycle, and the matching valid pulses two cycles after ack with data.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant;
  logic   grant_dread;
  logic   owner_dread;
`ifndef TEST_RAM_ARB_FIXED_PRIO_EN
  logic   last_dread;
`endif

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    grant_dread = 1'b0;
    case (state)
      IDLE: begin
        if (ifetch_req || dread_req) begin
          grant = 1'b1;
`ifdef TEST_RAM_ARB_FIXED_PRIO_EN
          grant_dread = !ifetch_req;
`else
          // On a tie, the port that did not own the previous access wins.
          grant_dread = dread_req && (!ifetch_req || !last_dread);
`endif
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ram_enable   <= 1'b0;
      ram_addr     <= '0;
      ifetch_ack   <= 1'b0;
      dread_ack    <= 1'b0;
      ifetch_valid <= 1'b0;
      dread_valid  <= 1'b0;
      ifetch_data  <= '0;
      dread_data   <= '0;
      owner_dread  <= 1'b0;
`ifndef TEST_RAM_ARB_FIXED_PRIO_EN
      last_dread   <= 1'b1;
`endif
    end else begin
      state      <= state_nxt;
      ram_enable <= grant;
      ifetch_ack <= grant && !grant_dread;
      dread_ack  <= grant && grant_dread;
      if (grant) begin
        ram_addr    <= grant_dread ? dread_addr : ifetch_addr;
        owner_dread <= grant_dread;
`ifndef TEST_RAM_ARB_FIXED_PRIO_EN
        last_dread  <= grant_dread;
`endif
      end
      // RAM output is valid during WAIT; hand it to the owner as the cycle ends.
      ifetch_valid <= (state == WAIT) && !owner_dread;
      dread_valid  <= (state == WAIT) && owner_dread;
      if (state == WAIT) begin
        if (owner_dread) dread_data  <= ram_data_in;
        else             ifetch_data <= ram_data_in;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_test_ram_arbiter.sv
// Testbench for test_ram_arbiter: directed scenarios plus randomized traffic against a timestamp model.
module tb_test_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rf = 1'b0, rd = 1'b0;
  logic [AW-1:0] af = '0, ad = '0;
  logic          ifetch_ack, ifetch_valid, dread_ack, dread_valid;
  logic [DW-1:0] ifetch_data, dread_data;
  logic          ram_enable, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q = '0;
  logic [1:0]    fsm_state;

  logic [7:0]    mem [256];

  int checks = 0;
  int failures = 0;

  test_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ifetch_req(rf), .ifetch_addr(af), .ifetch_ack(ifetch_ack),
    .ifetch_valid(ifetch_valid), .ifetch_data(ifetch_data),
    .dread_req(rd), .dread_addr(ad), .dread_ack(dread_ack),
    .dread_valid(dread_valid), .dread_data(dread_data),
    .ram_enable(ram_enable), .ram_addr(ram_addr), .ram_data_in(ram_q),
    .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Six consecutive bytes, big-endian, wrapping at the 256-byte depth.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    logic [7:0]    b;
    w = '0;
    for (int i = 0; i < 6; i++) begin
      b = a[7:0] + 8'(i);
      w = {w[DW-9:0], mem[b]};
    end
    return w;
  endfunction

  always @(posedge clk) if (ram_enable) ram_q <= ram_word(ram_addr);

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: access timestamps ----------------
  int            cyc = 0;
  bit            armed = 1'b0;
  int            ack_at = -1, val_at = -1, free_at = 0, grant_cyc = 0;
  bit            own_d = 1'b0, last_d = 1'b1, pick_d;
  logic [AW-1:0] addr_exp = '0;
  logic [DW-1:0] data_f_exp = '0, data_d_exp = '0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (armed) begin
      chk("m_ifetch_ack",   48'(ifetch_ack),   48'(ack_at == cyc && !own_d));
      chk("m_dread_ack",    48'(dread_ack),    48'(ack_at == cyc && own_d));
      chk("m_ram_enable",   48'(ram_enable),   48'(ack_at == cyc));
      chk("m_ifetch_valid", 48'(ifetch_valid), 48'(val_at == cyc && !own_d));
      chk("m_dread_valid",  48'(dread_valid),  48'(val_at == cyc && own_d));
      chk("m_busy",         48'(busy),         48'(cyc > grant_cyc && cyc < free_at));
      chk("m_ram_addr",     48'(ram_addr),     48'(addr_exp));
      chk("m_ifetch_data",  ifetch_data,       data_f_exp);
      chk("m_dread_data",   dread_data,        data_d_exp);
    end
    if (rst) begin
      armed = 1'b1;
      last_d = 1'b1;
      ack_at = -1; val_at = -1;
      grant_cyc = cyc; free_at = cyc + 1;
      addr_exp = '0; data_f_exp = '0; data_d_exp = '0;
      exp_q.delete();
    end else begin
      if (cyc == val_at - 1 && exp_q.size() > 0) begin
        if (own_d) data_d_exp = exp_q.pop_front();
        else       data_f_exp = exp_q.pop_front();
      end
      if (cyc >= free_at && (rf || rd)) begin
`ifdef TEST_RAM_ARB_FIXED_PRIO_EN
        pick_d = !rf;
`else
        if (rf && rd) pick_d = !last_d;
        else          pick_d = rd;
`endif
        own_d = pick_d; last_d = pick_d;
        grant_cyc = cyc; ack_at = cyc + 1; val_at = cyc + 3; free_at = cyc + 3;
        addr_exp = pick_d ? ad : af;
        exp_q.push_back(ram_word(addr_exp));
      end
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  int            order[$];
  logic [DW-1:0] dread_hold;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC;
    mem[8'h13] = 8'hDD; mem[8'h14] = 8'hEE; mem[8'h15] = 8'hFF;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    mem[8'h01] = 8'h44; mem[8'h02] = 8'h55; mem[8'h03] = 8'h66;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    chk("rst_ram_enable", 48'(ram_enable), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_ram_addr", 48'(ram_addr), 48'd0);
    chk("rst_data", {ifetch_data | dread_data}, 48'd0);

    // Single fetch at 0x10, request dropped during ISSUE.
    next_cycle(); rf = 1'b1; af = 32'h10;
    sample(); chk("f_c0_enable", 48'(ram_enable), 48'd0);
    next_cycle(); rf = 1'b0;
    sample();
    chk("f_c1_enable", 48'(ram_enable), 48'd1);
    chk("f_c1_ack", 48'(ifetch_ack), 48'd1);
    chk("f_c1_addr", 48'(ram_addr), 48'h10);
    next_cycle(); sample();
    chk("f_c2_enable", 48'(ram_enable), 48'd0);
    chk("f_c2_ack", 48'(ifetch_ack), 48'd0);
    next_cycle(); sample();
    chk("f_c3_valid", 48'(ifetch_valid), 48'd1);
    chk("f_c3_data", ifetch_data, 48'hAABBCCDDEEFF);
    chk("f_c3_dvalid", 48'(dread_valid), 48'd0);
    next_cycle(); sample();
    chk("f_c4_valid", 48'(ifetch_valid), 48'd0);
    chk("f_c4_no_reissue", 48'(ram_enable), 48'd0);

    // Data read at 0xFE: address unmasked, bytes wrap inside the RAM.
    next_cycle(); rd = 1'b1; ad = 32'hFE;
    next_cycle(); rd = 1'b0;
    sample();
    chk("d_ack", 48'(dread_ack), 48'd1);
    chk("d_addr", 48'(ram_addr), 48'hFE);
    next_cycle(); next_cycle(); sample();
    chk("d_valid", 48'(dread_valid), 48'd1);
    chk("d_data", dread_data, 48'h112233445566);
    chk("d_fetch_untouched", ifetch_data, 48'hAABBCCDDEEFF);

    // Reset pulse during WAIT discards the access; held request re-acked.
    next_cycle(); rd = 1'b1; ad = 32'h20;
    next_cycle();
    next_cycle(); rst = 1'b1;
    sample(); chk("r_wait_busy", 48'(busy), 48'd1);
    next_cycle(); rst = 1'b0;
    sample();
    chk("r_no_valid", 48'(dread_valid), 48'd0);
    chk("r_dread_data", dread_data, 48'd0);
    chk("r_ifetch_data", ifetch_data, 48'd0);
    chk("r_ram_addr", 48'(ram_addr), 48'd0);
    chk("r_busy", 48'(busy), 48'd0);
    next_cycle(); sample();
    chk("r_reack", 48'(dread_ack), 48'd1);
    chk("r_reack_addr", 48'(ram_addr), 48'h20);
    next_cycle(); rd = 1'b0;

    // Continuous contention: both requesters held for 12 cycles.
    next_cycle(); rf = 1'b1; af = 32'h00; rd = 1'b1; ad = 32'h40;
    for (int i = 0; i < 12; i++) begin
      next_cycle(); sample();
      if (ifetch_ack) order.push_back(0);
      if (dread_ack)  order.push_back(1);
    end
    chk("c_ack_count", 48'(order.size()), 48'd4);
    for (int i = 0; i < order.size(); i++) begin
`ifdef TEST_RAM_ARB_FIXED_PRIO_EN
      chk("c_ack_order", 48'(order[i]), 48'd0);
`else
      chk("c_ack_order", 48'(order[i]), 48'(i % 2));
`endif
    end
    next_cycle(); rf = 1'b0; rd = 1'b0;
    repeat (5) next_cycle();

    // Ten idle cycles: nothing issued, data registers keep their words.
`ifdef TEST_RAM_ARB_FIXED_PRIO_EN
    dread_hold = ram_word(32'h20);
`else
    dread_hold = ram_word(32'h40);
`endif
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("i_enable", 48'(ram_enable), 48'd0);
      chk("i_busy", 48'(busy), 48'd0);
      chk("i_fdata", ifetch_data, ram_word(32'h00));
      chk("i_ddata", dread_data, dread_hold);
      next_cycle();
    end

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 800; i++) begin
      next_cycle();
      rst = ($urandom_range(0, 39) == 0);
      if (!rf) begin
        if ($urandom_range(0, 3) == 0) begin rf = 1'b1; af = $urandom; end
      end else if (ifetch_ack) begin
        if ($urandom_range(0, 1) == 0) rf = 1'b0;
        else af = $urandom;
      end
      if (!rd) begin
        if ($urandom_range(0, 3) == 0) begin rd = 1'b1; ad = $urandom; end
      end else if (dread_ack) begin
        if ($urandom_range(0, 1) == 0) rd = 1'b0;
        else ad = $urandom;
      end
    end
    next_cycle(); rst = 1'b0; rf = 1'b0; rd = 1'b0;
    repeat (6) next_cycle();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
